port_input_conditioner: RTL

- Producer side of the CPU input port: conditions raw board inputs into the 8-bit PortIn word the datapath reads.
- Inputs: slide[3:0] and active-low button[1:0].
- Per input: 2-flop synchroniser, counter debounce, and a one-cycle press pulse for each button.
- port_in layout: {flags[1:0], btn_level[1:0], slide[3:0]}.
- Optional sticky press flags, cleared by the CPU side.

---
 rtl/port_input_conditioner.sv | 91 +++++++++
 1 files changed

// File: rtl/port_input_conditioner.sv
// Input-port conditioner: synchronises and debounces slide switches and active-low buttons into PortIn.
// Define PORTIN_STICKY_FLAGS_EN to add CPU-cleared sticky press flags at port_in[7:6].
module port_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] slide,
  input  logic [1:0] button,
  input  logic [1:0] flag_clr,
  output logic [7:0] port_in,
  output logic [1:0] btn_level,
  output logic [1:0] press_pulse
);

  localparam int              NCH      = 6;
  // Buttons idle high on the board, so their sync flops reset to 1 and are inverted after the chain.
  localparam logic [NCH-1:0]  ACT_LOW  = 6'b11_0000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   synced;
  logic [NCH-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [1:0]       press_q, press_d;
  logic [1:0]       flags;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= ACT_LOW;
    end else begin
      sync_q[0] <= {button, slide};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1] ^ ACT_LOW;

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = synced[i];
        else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
    press_d = stable_d[5:4] & ~stable_q[5:4];
  end

  // NOTE: the counter array is reset, unlike a RAM, because a stale count would shorten qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef PORTIN_STICKY_FLAGS_EN
  logic [1:0] flag_q, flag_d;

  // Set has priority over clear so a press landing on a clear strobe is not lost.
  assign flag_d = press_d | (flag_q & ~flag_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= '0;
    else        flag_q <= flag_d;
  end

  assign flags = flag_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = ^flag_clr;
  assign flags           = 2'b00;
`endif

  assign port_in     = {flags, stable_q[5:4], stable_q[3:0]};
  assign btn_level   = stable_q[5:4];
  assign press_pulse = press_q;

endmodule
